// File: rtl/nibble_serial_adder_if.sv
// rtl/nibble_serial_adder_if.sv - handshake and data bundle for nibble_serial_adder
//
// Purpose: groups the operand-side and result-side valid/ready channels.
//   slave  : adder view (accepts operands, produces the result)
//   master : producer/consumer view (drives operands, takes the result)
// Signals:
//   in_valid / in_ready    operand handshake
//   a, b, cin              operands and carry into bit 0
//   out_valid / out_ready  result handshake
//   sum, cout              registered result and carry out of bit WIDTH-1
//   ovf                    signed overflow, present only with SERIAL_ADD_OVF_EN
interface nibble_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;
`endif

  modport slave (
    input  in_valid, a, b, cin, out_ready,
`ifdef SERIAL_ADD_OVF_EN
    output ovf,
`endif
    output in_ready, out_valid, sum, cout
  );

  modport master (
    output in_valid, a, b, cin, out_ready,
`ifdef SERIAL_ADD_OVF_EN
    input  ovf,
`endif
    input  in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - WIDTH-bit adder processing one 4-bit lookahead nibble per clock
//
// Purpose: accepts a, b, cin on the operand handshake, adds them LSB nibble
//   first through a single 4-bit carry-lookahead slice with the carry held in
//   a flop between steps, then holds sum/cout until the result handshake.
//   Latency from accept edge to out_valid is WIDTH/4 cycles.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    nibble_serial_adder_if.slave (in_valid/in_ready, a, b, cin,
//          out_valid/out_ready, sum, cout, ovf)
// Optional feature macro: SERIAL_ADD_OVF_EN adds the signed-overflow output ovf.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  nibble_serial_adder_if.slave bus
);
  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q;
`endif

  logic             in_ready_c;
  logic             out_valid_c;
  logic             accept;
  logic             last;

  // 4-bit carry-lookahead slice on the low nibbles, fully expanded carries
  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] s;
  logic       c1;
  logic       c2;
  logic       c3;
  logic       c4;

  assign g  = a_q[3:0] & b_q[3:0];
  assign p  = a_q[3:0] ^ b_q[3:0];
  assign c1 = g[0] | (p[0] & carry_q);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_q);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
            | (p[2] & p[1] & p[0] & carry_q);
  assign c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & carry_q);
  assign s  = p ^ {c3, c2, c1, carry_q};

  assign accept = (state_q == IDLE) && bus.in_valid;
  assign last   = (state_q == RUN) && (cnt_q == CW'(NIB - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Handshake outputs decode from the state flops only
  always_comb begin
    state_d     = state_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) state_d = RUN;
      end
      RUN: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      if (accept) begin
        a_q     <= bus.a;
        b_q     <= bus.b;
        carry_q <= bus.cin;
        cnt_q   <= '0;
      end else if (state_q == RUN) begin
        a_q     <= a_q >> 4;
        b_q     <= b_q >> 4;
        // Nibble sums enter at the top so the LSB nibble ends at bit 0
        sum_q   <= (sum_q >> 4) | (WIDTH'(s) << (WIDTH - 4));
        carry_q <= c4;
        cnt_q   <= cnt_q + CW'(1);
`ifdef SERIAL_ADD_OVF_EN
        // Carry into vs. out of the MSB on the top nibble
        if (last) ovf_q <= c3 ^ c4;
`endif
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.sum       = sum_q;
  assign bus.cout      = carry_q;
`ifdef SERIAL_ADD_OVF_EN
  assign bus.ovf       = ovf_q;
`endif
endmodule
